// File: rtl/controle_concatena_if.sv
// Digit handshake between the keypad decoder and the concatenation sequencer.
// The source drives a BCD digit with a valid flag; the sequencer answers with ready.
interface controle_concatena_if;
  logic       DigitoValido;
  logic [3:0] Digito;
  logic       DigitoPronto;

  modport master (
    output DigitoValido,
    output Digito,
    input  DigitoPronto
  );

  modport slave (
    input  DigitoValido,
    input  Digito,
    output DigitoPronto
  );
endinterface

// File: rtl/controle_concatena.sv
// Sequencer for the 12-bit digit-concatenation register: shifts in up to
// three BCD digits, supports backspace and confirm, flags non-BCD digits.
module controle_concatena #(
  parameter int NUM_DIGITOS = 3,
  parameter int LARG_DIGITO = 4,
  localparam int W = NUM_DIGITOS * LARG_DIGITO
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Iniciar,
  input  logic                  Apagar,
  input  logic                  Confirmar,
  controle_concatena_if.slave   dig,
  output logic [W-1:0]          Valor,
  output logic [1:0]            Contagem,
  output logic                  Pronto,
  output logic                  Erro
);

  typedef enum logic [2:0] {
    OCIOSO,
    LIMPA,
    COLETA,
    CHEIO,
    CONCLUIDO
  } estado_t;

  estado_t        state_q, state_d;
  logic [W-1:0]   valor_q, valor_d;
  logic [1:0]     contagem_q, contagem_d;
  logic           pronto_q, pronto_d;
  logic           erro_q, erro_d;
  logic           digito_pronto;
  logic           tem_digito;
  logic [1:0]     cont_mais;
  logic [1:0]     cont_menos;
  logic [W-1:0]   valor_ins;
  logic [W-1:0]   valor_rem;

  assign digito_pronto = (state_q == COLETA) & !Iniciar
                       & !Apagar & !Confirmar;
  assign dig.DigitoPronto = digito_pronto;

  assign tem_digito = (contagem_q != 2'd0);
  assign cont_mais  = contagem_q + 2'd1;
  assign cont_menos = contagem_q - 2'd1;
  assign valor_ins  = {valor_q[W-LARG_DIGITO-1:0], dig.Digito};
  assign valor_rem  = {{LARG_DIGITO{1'b0}}, valor_q[W-1:LARG_DIGITO]};

  always_comb begin
    state_d    = state_q;
    valor_d    = valor_q;
    contagem_d = contagem_q;
    pronto_d   = pronto_q;
    erro_d     = 1'b0;
    if (Iniciar) begin
      // Clearing on the Iniciar edge makes zero visible one cycle early.
      state_d    = LIMPA;
      valor_d    = '0;
      contagem_d = 2'd0;
      pronto_d   = 1'b0;
    end else begin
      unique case (state_q)
        OCIOSO: ;
        LIMPA: begin
          valor_d    = '0;
          contagem_d = 2'd0;
          pronto_d   = 1'b0;
          state_d    = COLETA;
        end
        COLETA: begin
          if (Apagar) begin
            if (tem_digito) begin
              valor_d    = valor_rem;
              contagem_d = cont_menos;
            end
          end else if (Confirmar) begin
            if (tem_digito) begin
              state_d  = CONCLUIDO;
              pronto_d = 1'b1;
            end
          end else if (dig.DigitoValido) begin
            if (dig.Digito <= 4'd9) begin
              valor_d    = valor_ins;
              contagem_d = cont_mais;
              if (cont_mais == 2'(NUM_DIGITOS))
                state_d = CHEIO;
            end else begin
              erro_d = 1'b1;
            end
          end
        end
        CHEIO: begin
          if (Apagar) begin
            valor_d    = valor_rem;
            contagem_d = cont_menos;
            state_d    = COLETA;
          end else if (Confirmar) begin
            state_d  = CONCLUIDO;
            pronto_d = 1'b1;
          end
        end
        CONCLUIDO: ;
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= OCIOSO;
      valor_q    <= '0;
      contagem_q <= 2'd0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valor_q    <= valor_d;
      contagem_q <= contagem_d;
      pronto_q   <= pronto_d;
      erro_q     <= erro_d;
    end
  end

  assign Valor    = valor_q;
  assign Contagem = contagem_q;
  assign Pronto   = pronto_q;
  assign Erro     = erro_q;

endmodule

// File: tb/tb_controle_concatena.sv
// Directed bench for controle_concatena: fill, backspace, confirm,
// digit rejection, empty-entry edge cases and mid-entry reset.
module tb_controle_concatena;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Iniciar;
  logic        Apagar;
  logic        Confirmar;
  logic [11:0] Valor;
  logic [1:0]  Contagem;
  logic        Pronto;
  logic        Erro;

  int checks = 0;
  int failures = 0;

  controle_concatena_if dif ();

  controle_concatena dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Iniciar   (Iniciar),
    .Apagar    (Apagar),
    .Confirmar (Confirmar),
    .dig       (dif),
    .Valor     (Valor),
    .Contagem  (Contagem),
    .Pronto    (Pronto),
    .Erro      (Erro)
  );

  always #5 Clock = ~Clock;

  // Edge, then release one-shot controls and let combinational logic settle.
  task automatic tick;
    @(posedge Clock);
    #1;
    Iniciar = 1'b0;
    Apagar = 1'b0;
    Confirmar = 1'b0;
    dif.DigitoValido = 1'b0;
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    dif.DigitoValido = 1'b1;
    dif.Digito = d;
    tick();
  endtask

  task automatic start_entry;
    Iniciar = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (Valor !== 12'h000 || Contagem !== 2'd0) begin
      failures++;
      $display("FAIL reset_valor: got %h/%0d want 000/0", Valor, Contagem);
    end
    checks++;
    if (Pronto !== 1'b0 || Erro !== 1'b0 || dif.DigitoPronto !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got P=%b E=%b R=%b want 0 0 0",
               Pronto, Erro, dif.DigitoPronto);
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill;
    Iniciar = 1'b1;
    tick();
    checks++;
    if (Valor !== 12'h000 || Contagem !== 2'd0 || dif.DigitoPronto !== 1'b0) begin
      failures++;
      $display("FAIL fill_limpa: got %h/%0d R=%b want 000/0 R=0",
               Valor, Contagem, dif.DigitoPronto);
    end
    tick();
    checks++;
    if (dif.DigitoPronto !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready: got %b want 1", dif.DigitoPronto);
    end
    send_digit(4'd1);
    checks++;
    if (Valor !== 12'h001 || Contagem !== 2'd1) begin
      failures++;
      $display("FAIL fill_d1: got %h/%0d want 001/1", Valor, Contagem);
    end
    send_digit(4'd2);
    send_digit(4'd3);
    checks++;
    if (Valor !== 12'h123 || Contagem !== 2'd3 || dif.DigitoPronto !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: got %h/%0d R=%b want 123/3 R=0",
               Valor, Contagem, dif.DigitoPronto);
    end
    send_digit(4'd4);
    checks++;
    if (Valor !== 12'h123 || Contagem !== 2'd3 || Erro !== 1'b0) begin
      failures++;
      $display("FAIL fill_fourth: got %h/%0d E=%b want 123/3 E=0",
               Valor, Contagem, Erro);
    end
    send_digit(4'hC);
    checks++;
    if (Erro !== 1'b0 || Valor !== 12'h123) begin
      failures++;
      $display("FAIL cheio_noerr: got E=%b %h want E=0 123", Erro, Valor);
    end
  endtask

  task automatic test_cheio_exit;
    Apagar = 1'b1;
    tick();
    checks++;
    if (Valor !== 12'h012 || Contagem !== 2'd2 || dif.DigitoPronto !== 1'b1) begin
      failures++;
      $display("FAIL cheio_apagar: got %h/%0d R=%b want 012/2 R=1",
               Valor, Contagem, dif.DigitoPronto);
    end
    send_digit(4'd8);
    Confirmar = 1'b1;
    tick();
    checks++;
    if (Pronto !== 1'b1 || Valor !== 12'h128) begin
      failures++;
      $display("FAIL cheio_confirm: got P=%b %h want P=1 128", Pronto, Valor);
    end
    Iniciar = 1'b1;
    tick();
    checks++;
    if (Pronto !== 1'b0 || Valor !== 12'h000 || Contagem !== 2'd0) begin
      failures++;
      $display("FAIL restart: got P=%b %h/%0d want P=0 000/0",
               Pronto, Valor, Contagem);
    end
  endtask

  task automatic test_backspace_confirm;
    start_entry();
    send_digit(4'd4);
    send_digit(4'd5);
    Apagar = 1'b1;
    tick();
    checks++;
    if (Valor !== 12'h004 || Contagem !== 2'd1) begin
      failures++;
      $display("FAIL bksp: got %h/%0d want 004/1", Valor, Contagem);
    end
    Confirmar = 1'b1;
    tick();
    checks++;
    if (Pronto !== 1'b1 || Valor !== 12'h004) begin
      failures++;
      $display("FAIL confirm: got P=%b %h want P=1 004", Pronto, Valor);
    end
    for (int i = 0; i < 10; i++) begin
      dif.DigitoValido = 1'b1;
      dif.Digito = 4'(i % 10);
      Apagar = (i % 2) == 1;
      Confirmar = (i % 3) == 0;
      tick();
      checks++;
      if (Pronto !== 1'b1 || Valor !== 12'h004 || Contagem !== 2'd1) begin
        failures++;
        $display("FAIL hold_%0d: got P=%b %h/%0d want P=1 004/1",
                 i, Pronto, Valor, Contagem);
      end
    end
  endtask

  task automatic test_erro;
    start_entry();
    send_digit(4'hB);
    checks++;
    if (Erro !== 1'b1 || Valor !== 12'h000 || Contagem !== 2'd0) begin
      failures++;
      $display("FAIL erro_pulse: got E=%b %h/%0d want E=1 000/0",
               Erro, Valor, Contagem);
    end
    tick();
    checks++;
    if (Erro !== 1'b0) begin
      failures++;
      $display("FAIL erro_clear: got %b want 0", Erro);
    end
    send_digit(4'd7);
    checks++;
    if (Valor !== 12'h007 || Contagem !== 2'd1 || Erro !== 1'b0) begin
      failures++;
      $display("FAIL erro_then7: got %h/%0d E=%b want 007/1 E=0",
               Valor, Contagem, Erro);
    end
  endtask

  task automatic test_empty_ops;
    start_entry();
    Confirmar = 1'b1;
    tick();
    checks++;
    if (Pronto !== 1'b0 || dif.DigitoPronto !== 1'b1) begin
      failures++;
      $display("FAIL empty_confirm: got P=%b R=%b want P=0 R=1",
               Pronto, dif.DigitoPronto);
    end
    Apagar = 1'b1;
    tick();
    checks++;
    if (Valor !== 12'h000 || Contagem !== 2'd0 || dif.DigitoPronto !== 1'b1) begin
      failures++;
      $display("FAIL empty_apagar: got %h/%0d R=%b want 000/0 R=1",
               Valor, Contagem, dif.DigitoPronto);
    end
  endtask

  task automatic test_apagar_digit;
    start_entry();
    send_digit(4'd1);
    send_digit(4'd2);
    Apagar = 1'b1;
    dif.DigitoValido = 1'b1;
    dif.Digito = 4'd9;
    #1;
    checks++;
    if (dif.DigitoPronto !== 1'b0) begin
      failures++;
      $display("FAIL apagar_ready: got %b want 0", dif.DigitoPronto);
    end
    tick();
    checks++;
    if (Valor !== 12'h001 || Contagem !== 2'd1) begin
      failures++;
      $display("FAIL apagar_digit: got %h/%0d want 001/1", Valor, Contagem);
    end
  endtask

  task automatic test_reset_mid;
    start_entry();
    send_digit(4'd5);
    send_digit(4'd6);
    checks++;
    if (Valor !== 12'h056) begin
      failures++;
      $display("FAIL mid_setup: got %h want 056", Valor);
    end
    Reset_n = 1'b0;
    Iniciar = 1'b1;
    tick();
    checks++;
    if (Valor !== 12'h000 || Contagem !== 2'd0 || Pronto !== 1'b0 ||
        Erro !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got %h/%0d P=%b E=%b want 000/0 0 0",
               Valor, Contagem, Pronto, Erro);
    end
    Reset_n = 1'b1;
    send_digit(4'd5);
    checks++;
    if (Valor !== 12'h000 || dif.DigitoPronto !== 1'b0) begin
      failures++;
      $display("FAIL ocioso_ignore: got %h R=%b want 000 R=0",
               Valor, dif.DigitoPronto);
    end
    Iniciar = 1'b1;
    tick();
    checks++;
    if (Valor !== 12'h000 || dif.DigitoPronto !== 1'b0) begin
      failures++;
      $display("FAIL post_iniciar: got %h R=%b want 000 R=0",
               Valor, dif.DigitoPronto);
    end
    tick();
    checks++;
    if (dif.DigitoPronto !== 1'b1) begin
      failures++;
      $display("FAIL post_coleta: got R=%b want 1", dif.DigitoPronto);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Iniciar = 1'b0;
    Apagar = 1'b0;
    Confirmar = 1'b0;
    dif.DigitoValido = 1'b0;
    dif.Digito = 4'd0;
    test_reset();
    test_fill();
    test_cheio_exit();
    test_backspace_confirm();
    test_erro();
    test_empty_ops();
    test_apagar_digit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_concatena.md
# controle_concatena

Sequencer for the 12-bit digit-concatenation register. It seeds the register with the 12-bit all-zero initial value, then accepts up to three 4-bit BCD digits through a valid/ready handshake. Each digit is shifted in from the right. Backspace and confirm are supported. The block sits between the digit source (keypad decoder) and the downstream consumer of the assembled 12-bit value, which samples `Valor` when `Pronto` is high.

## Interface
- `NUM_DIGITOS`, 3: maximum digits held.
- `LARG_DIGITO`, 4: bits per digit.
- Derived: register width W = NUM_DIGITOS*LARG_DIGITO = 12. Not overridable.

Ports:
- `Clock`  in  1: single clock. All state changes on the rising edge.
- `Reset_n`  in  1: synchronous, active-low reset.
- `Iniciar`  in  1: start a new entry; clears the register.
- `DigitoValido`  in  1: `Digito` is valid this cycle.
- `Digito`  in  4: BCD digit, legal range 0–9.
- `DigitoPronto`  out  1: block can accept a digit this cycle.
- `Apagar`  in  1: backspace; removes the last digit.
- `Confirmar`  in  1: close the entry.
- `Valor`  out  12: assembled value, most-recent digit in [3:0].
- `Contagem`  out  2: number of digits currently held, 0–3.
- `Pronto`  out  1: entry confirmed; `Valor` is stable.
- `Erro`  out  1: one-cycle pulse when a non-BCD digit is rejected.

## Operation
- States: OCIOSO, LIMPA, COLETA, CHEIO, CONCLUIDO.
- Reset (`Reset_n`=0 at an edge):
  - state=OCIOSO, `Valor`=0, `Contagem`=0, `Pronto`=0, `Erro`=0.
  - Reset has priority over all inputs, in every state.
- Input priority, highest first: `Iniciar` > `Apagar` > `Confirmar` > digit.
- `Iniciar`, any state → LIMPA. In LIMPA: `Valor`←12'b0, `Contagem`←0, `Pronto`←0. LIMPA → COLETA unconditionally after one cycle.
- `DigitoPronto` (combinational) = (state==COLETA) & !`Iniciar` & !`Apagar` & !`Confirmar`.
- Digit accept requires `DigitoValido` & `DigitoPronto`:
  - `Digito` ≤ 9: `Valor`←{`Valor`[7:0], `Digito`}, `Contagem`←`Contagem`+1. If the new count is 3, → CHEIO.
  - `Digito` > 9: `Valor` and `Contagem` unchanged; `Erro`←1 for exactly one cycle.
- `Apagar` in COLETA or CHEIO with `Contagem`>0:
  - `Valor`←{4'b0, `Valor`[11:4]}, `Contagem`←`Contagem`−1.
  - CHEIO → COLETA.
  - With `Contagem`=0: no effect.
- `Confirmar` in COLETA with `Contagem`>0, or in CHEIO: → CONCLUIDO, `Pronto`←1.
- `Confirmar` with `Contagem`=0: ignored; state stays COLETA.
- CHEIO: digits are not accepted (`DigitoPronto`=0). `DigitoValido` is ignored and no `Erro` is raised.
- CONCLUIDO: `Valor`, `Contagem` and `Pronto`=1 are held. `Apagar`, `Confirmar` and digits are ignored. Only `Iniciar` or reset leaves this state.
- OCIOSO: everything except `Iniciar` is ignored. Outputs keep their reset values.
- No arithmetic is performed beyond shifts and the 2-bit count. `Contagem` never wraps: +1 only below 3, −1 only above 0.

## Timing
- All outputs except `DigitoPronto` are registered. `DigitoPronto` is combinational from state and inputs.
- `Iniciar` sampled at edge N:
  - `Valor`=0 and `Contagem`=0 are visible after edge N (state LIMPA).
  - State is COLETA after edge N+1.
  - `DigitoPronto` can first be 1 in the cycle following edge N+1.
- Digit accepted at edge N: the new `Valor`/`Contagem` are visible after edge N. Back-to-back digits can be accepted on consecutive edges.
- Rejected digit at edge N: `Erro`=1 in cycle N..N+1, and 0 after edge N+1 unless another digit is rejected.
- `Confirmar` at edge N: `Pronto`=1 from edge N onward.
- `Iniciar` while in CONCLUIDO: `Pronto`=0 after that edge.
- Simultaneous `Apagar` + valid digit: backspace executes; the digit is not accepted, because `DigitoPronto`=0 in that cycle.
- `Reset_n` low mid-entry: returns to OCIOSO at that edge, regardless of the other inputs.

## Test plan
- Reset, then `Iniciar`, then digits 1, 2, 3 on consecutive cycles → `Valor`=12'h123, `Contagem`=3, state CHEIO, `DigitoPronto`=0. A fourth digit 4 is ignored and `Valor` stays 12'h123.
- Digits 4, 5, then `Apagar` → `Valor`=12'h004, `Contagem`=1. Then `Confirmar` → `Pronto`=1 and `Valor`=12'h004 held for 10 cycles while further digits and `Apagar` are applied.
- In COLETA, digit 4'hB → `Erro`=1 for exactly one cycle; `Valor` and `Contagem` unchanged. Then digit 7 → `Valor`=12'h007.
- `Confirmar` with `Contagem`=0 → `Pronto` stays 0 and state stays COLETA. `Apagar` with `Contagem`=0 → no change.
- `Apagar` and a valid digit 9 in the same cycle with `Valor`=12'h012 → `Valor`=12'h001, `Contagem`=1.
- Mid-entry (`Valor`=12'h056), assert `Reset_n`=0 together with `Iniciar`=1 → all outputs 0 and state OCIOSO. After release, `Iniciar` → `Valor`=0 and COLETA is reached 2 edges later.
